// File: rtl/cla_pkg.sv
// Shared types and sizing helpers for the pipelined carry-lookahead adder.
//   gp_t      : group generate/propagate pair produced by each cla_group
//   slice_w   : bits resolved per pipeline stage (WIDTH / PIPE_DEPTH)
//   group_cnt : cla_group instances per stage (WIDTH / (BLK * PIPE_DEPTH))
package cla_pkg;

    typedef struct packed {
        logic g;
        logic p;
    } gp_t;

    function automatic int slice_w(input int width, input int depth);
        return width / depth;
    endfunction

    function automatic int group_cnt(input int width, input int blk, input int depth);
        return width / (blk * depth);
    endfunction

endpackage

// File: rtl/cla_group.sv
// BLK-bit carry-lookahead group (purely combinational).
//   a, b   : group operand bits
//   cin    : carry into bit 0 of the group
//   s      : group sum bits
//   cout   : carry out of the group
//   gp     : group generate / propagate for the next lookahead level
//   c_msb  : carry into the group's top bit (feeds signed overflow)
module cla_group
    import cla_pkg::*;
#(
    parameter int BLK = 4
) (
    input  logic [BLK-1:0] a,
    input  logic [BLK-1:0] b,
    input  logic           cin,
    output logic [BLK-1:0] s,
    output logic           cout,
    output gp_t            gp,
    output logic           c_msb
);

    logic [BLK-1:0] g;
    logic [BLK-1:0] p;
    logic [BLK-1:0] c;

    assign g = a & b;
    assign p = a ^ b;

    // Every bit carry is formed straight from cin using the running
    // prefix (gacc, pacc) of the bits below it, so no carry waits on the
    // carry of its neighbour.
    always_comb begin
        logic gacc;
        logic pacc;
        c    = '0;
        gacc = 1'b0;
        pacc = 1'b1;
        for (int i = 0; i < BLK; i++) begin
            c[i] = gacc | (pacc & cin);
            gacc = g[i] | (p[i] & gacc);
            pacc = pacc & p[i];
        end
        gp.g = gacc;
        gp.p = pacc;
        cout = gacc | (pacc & cin);
    end

    assign s     = p ^ c;
    assign c_msb = c[BLK-1];

endmodule

// File: rtl/cla_adder_pipe.sv
// Pipelined carry-lookahead adder/subtractor.
// The operands are cut into PIPE_DEPTH slices; stage k resolves slice k
// with the carry registered by stage k-1, so latency is PIPE_DEPTH cycles
// at one beat per cycle. Any output stall freezes the whole pipe.
//   clk, rst             : clock, asynchronous active-high reset
//   in_valid / in_ready  : operand handshake (in_ready = !stall)
//   a_in, b_in           : operands
//   c_in                 : carry in (ignored when subtracting)
//   sub_in               : 0 -> a+b+c_in, 1 -> a-b
//   out_valid/out_ready  : result handshake
//   sum_o, c_o, ovf_o    : result, carry out of MSB, signed overflow
module cla_adder_pipe
    import cla_pkg::*;
#(
    parameter int WIDTH      = 32,
    parameter int BLK        = 4,
    parameter int PIPE_DEPTH = 2
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] a_in,
    input  logic [WIDTH-1:0] b_in,
    input  logic             c_in,
    input  logic             sub_in,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] sum_o,
    output logic             c_o,
    output logic             ovf_o
);

    localparam int SW = slice_w(WIDTH, PIPE_DEPTH);
    localparam int NG = group_cnt(WIDTH, BLK, PIPE_DEPTH);

    if (PIPE_DEPTH < 1 || BLK < 1 || (WIDTH % (BLK * PIPE_DEPTH)) != 0) begin : g_bad_cfg
        $fatal(1, "cla_adder_pipe: WIDTH must be a multiple of BLK*PIPE_DEPTH");
    end

    logic [PIPE_DEPTH:1] vld_pipe;
    logic                stall;
    logic                adv;
    logic                acc;
    logic [WIDTH-1:0]    b_eff;
    logic                cin_eff;

    // Only a full output stage that downstream refuses can stall; the
    // stall then backs up combinationally to in_ready.
    assign stall     = vld_pipe[PIPE_DEPTH] & ~out_ready;
    assign adv       = ~stall;
    assign in_ready  = adv;
    assign acc       = in_valid & adv;
    assign out_valid = vld_pipe[PIPE_DEPTH];

    // Subtraction is a + ~b + 1.
    assign b_eff   = sub_in ? ~b_in : b_in;
    assign cin_eff = sub_in | c_in;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            vld_pipe <= '0;
        end else if (adv) begin
            vld_pipe[1] <= acc;
            for (int k = 2; k <= PIPE_DEPTH; k++) begin
                vld_pipe[k] <= vld_pipe[k-1];
            end
        end
    end

    for (genvar k = 0; k < PIPE_DEPTH; k++) begin : g_stage
        // b bits not yet consumed when entering this stage
        localparam int BW = (PIPE_DEPTH - k) * SW;

        logic             vin;
        logic [WIDTH-1:0] src_w;   // {a slices still to add, sum slices done}
        logic [BW-1:0]    src_b;   // remaining b slices, current one at bit 0
        logic             src_c;
        logic [WIDTH-1:0] w_d;
        logic [SW-1:0]    s_s;
        logic [NG-1:0]    cg;      // carry into each group
        logic [NG-1:0]    co_g;
        logic [NG-1:0]    cm_g;
        gp_t  [NG-1:0]    gp;
        logic [WIDTH-1:0] w_q;
        logic             c_q;

        if (k == 0) begin : g_src
            assign vin   = acc;
            assign src_w = a_in;
            assign src_b = b_eff;
            assign src_c = cin_eff;
        end else begin : g_src
            assign vin   = vld_pipe[k];
            assign src_w = g_stage[k-1].w_q;
            assign src_b = g_stage[k-1].g_bq.b_q;
            assign src_c = g_stage[k-1].c_q;
        end

        for (genvar j = 0; j < NG; j++) begin : g_grp
            cla_group #(.BLK(BLK)) u_grp (
                .a     (src_w[k*SW + j*BLK +: BLK]),
                .b     (src_b[j*BLK +: BLK]),
                .cin   (cg[j]),
                .s     (s_s[j*BLK +: BLK]),
                .cout  (co_g[j]),
                .gp    (gp[j]),
                .c_msb (cm_g[j])
            );
        end

        // Second lookahead level: each group carry comes straight from the
        // stage carry-in and the group g/p prefix below it.
        always_comb begin
            logic gacc;
            logic pacc;
            cg   = '0;
            gacc = 1'b0;
            pacc = 1'b1;
            for (int j = 0; j < NG; j++) begin
                cg[j] = gacc | (pacc & src_c);
                gacc  = gp[j].g | (gp[j].p & gacc);
                pacc  = pacc & gp[j].p;
            end
        end

        // The sum slice replaces the a slice it was computed from, so the
        // word becomes the finished sum by the last stage.
        always_comb begin
            w_d               = src_w;
            w_d[k*SW +: SW]   = s_s;
        end

        // Registers load only on a valid beat: bubbles leave stale data in
        // place and the output stage changes only when a result lands.
        always_ff @(posedge clk or posedge rst) begin
            if (rst) begin
                w_q <= '0;
                c_q <= 1'b0;
            end else if (adv && vin) begin
                w_q <= w_d;
                c_q <= co_g[NG-1];
            end
        end

        if (k < PIPE_DEPTH - 1) begin : g_bq
            logic [BW-SW-1:0] b_q;
            always_ff @(posedge clk or posedge rst) begin
                if (rst) begin
                    b_q <= '0;
                end else if (adv && vin) begin
                    b_q <= src_b[BW-1:SW];
                end
            end
        end

        if (k == PIPE_DEPTH - 1) begin : g_ovf
            logic ovf_q;
            always_ff @(posedge clk or posedge rst) begin
                if (rst) begin
                    ovf_q <= 1'b0;
                end else if (adv && vin) begin
                    ovf_q <= cm_g[NG-1] ^ co_g[NG-1];
                end
            end
        end
    end

    assign sum_o = g_stage[PIPE_DEPTH-1].w_q;
    assign c_o   = g_stage[PIPE_DEPTH-1].c_q;
    assign ovf_o = g_stage[PIPE_DEPTH-1].g_ovf.ovf_q;

endmodule
